bongo_press_encoder: RTL

Input-side transmitter for the bongo hit path. Conditions the raw board push-buttons (synchronise, debounce, edge-detect) and emits one-cycle press events carrying the same 2-bit lane code used in the note stream (01 = KEY1, 10 = KEY2, 11 = KEY0). It also drives the level `go` consumed by each `hit_detector` instance. It sits between the board pins and the hit detectors; simultaneous presses are serialised, never merged or lost.

---
 rtl/bongo_pkg.sv | 39 +++
 rtl/key_debounce.sv | 55 +++++
 rtl/bongo_press_encoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/bongo_pkg.sv
// Shared definitions for the bongo hit path: lane codes used by the note stream,
// the hit detectors and the press encoder, plus the encoder FSM state encoding.
package bongo_pkg;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_NONE = 2'b00;
  localparam lane_t LANE_K1   = 2'b01;
  localparam lane_t LANE_K2   = 2'b10;
  localparam lane_t LANE_K0   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StGap
  } state_e;

  // Pending bit index is the key number: bit0 = KEY0, bit1 = KEY1, bit2 = KEY2.
  function automatic logic [2:0] lane_mask(lane_t lane);
    logic [2:0] mask;
    mask = 3'b000;
    case (lane)
      LANE_K0: mask = 3'b001;
      LANE_K1: mask = 3'b010;
      LANE_K2: mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Arbitration order is KEY1 > KEY2 > KEY0.
  function automatic lane_t pick_lane(logic [2:0] pend);
    if (pend[1]) return LANE_K1;
    if (pend[2]) return LANE_K2;
    if (pend[0]) return LANE_K0;
    return LANE_NONE;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One board key: synchroniser on the inverted (active-high) input, then an
// equality-terminated debounce counter producing a level and a rising-edge pulse.
module key_debounce
  import bongo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic reset_b,
  input  logic key_n,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The debouncer sees a new raw level two edges after it is first captured.
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], ~key_n};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[2] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[2];
        rise_d  = sync_q[2];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/bongo_press_encoder.sv
// Debounces the four board keys and serialises KEY0..KEY2 presses into one-cycle
// lane-coded strobes, with an optional idle gap after each strobe.
module bongo_press_encoder
  import bongo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned HOLDOFF_CYCLES  = 0
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [3:0] key_n,
  output logic [3:0] held,
  output logic       go,
  output logic       press,
  output logic [1:0] press_code,
  output logic       overrun
);

  localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_CYCLES - 1);

  logic [3:0] level, rise;
  logic       unused_rise3;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk    (clk),
      .reset_b(reset_b),
      .key_n  (key_n[i]),
      .level  (level[i]),
      .rise   (rise[i])
    );
  end

  assign unused_rise3 = rise[3];

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       pending_q, pending_d, clr, remaining;
  logic             overrun_q, overrun_d;
  logic             press_q, press_d;
  lane_t            code_q, code_d, sel;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hold_q    <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
      press_q   <= 1'b0;
      code_q    <= LANE_NONE;
    end else begin
      hold_q    <= hold_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      press_q   <= press_d;
      code_q    <= code_d;
    end
  end

  // The strobe being emitted right now owns the pending clear for this cycle.
  always_comb begin
    clr       = (state_q == StEmit) ? lane_mask(code_q) : 3'b000;
    remaining = pending_q & ~clr;
    sel       = pick_lane(remaining);
    state_d   = state_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if (|pending_q) state_d = StEmit;
      end
      StEmit: begin
        if (HOLDOFF_CYCLES > 0) begin
          state_d = StGap;
          hold_d  = '0;
        end else begin
          state_d = (|remaining) ? StEmit : StIdle;
        end
      end
      StGap: begin
        // Leaving the gap re-arbitrates at once so strobes stay 1 + holdoff apart.
        if (hold_q == HoldLast) begin
          state_d = (|pending_q) ? StEmit : StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A set colliding with a same-bit clear wins silently; only a set on a live bit overruns.
  always_comb begin
    pending_d = remaining | rise[2:0];
    overrun_d = overrun_q | (|(rise[2:0] & remaining));
    press_d   = (state_d == StEmit);
    code_d    = press_d ? sel : LANE_NONE;
  end

  assign held       = level;
  assign go         = |level[2:0];
  assign press      = press_q;
  assign press_code = code_q;
  assign overrun    = overrun_q;

endmodule
